// File: rtl/seg_pkg.sv
// seg_pkg -- shared definitions for the seven-segment readback decoder.
//
// Holds the active-low segment patterns {g,f,e,d,c,b,a} (bit0 = a) for the
// ten decimal digits, the all-off pattern, and the decoder FSM state type.
// Optional feature macro used by the top: SEG_READBACK_ERRCNT_EN.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Indexed by digit value so the LUT can be generated.
  localparam logic [6:0] SEG_DIGITS [10] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } seg_state_t;

endpackage

// File: rtl/seg_pattern_lut.sv
// seg_pattern_lut -- combinational decode of one active-low 7-segment pattern.
//
// Ports:
//   i_seg      [6:0] active-low segment lines {g,f,e,d,c,b,a}
//   o_digit    [3:0] decoded digit (0 when the pattern is not a digit)
//   o_is_digit       pattern matches one of the ten digit glyphs
//   o_is_blank       pattern is all segments off
module seg_pattern_lut
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_is_digit,
  output logic       o_is_blank
);

  logic [9:0] w_hit;

  for (genvar gi = 0; gi < 10; gi++) begin : g_hit
    assign w_hit[gi] = (i_seg == SEG_DIGITS[gi]);
  end

  // Glyphs are mutually exclusive, so at most one hit bit is set.
  always_comb begin
    o_digit = '0;
    for (int i = 0; i < 10; i++) begin
      if (w_hit[i]) o_digit = 4'(i);
    end
  end

  assign o_is_digit = |w_hit;
  assign o_is_blank = (i_seg == SEG_BLANK);

endmodule

// File: rtl/seg_readback_decoder.sv
// seg_readback_decoder -- debounces and decodes a 7-segment readback bus.
//
// A pattern is accepted once the registered sample has stayed identical for
// STABLE_CYCLES consecutive comparisons; acceptance pulses valid for one cycle
// and updates digit/score_lo (digits), blank (all-off) or err (anything else).
//
// Parameters:
//   STABLE_CYCLES  2..15, identical samples required before acceptance
// Ports:
//   clk               clock, all state on rising edge
//   rst_n             asynchronous active-low reset
//   seg      [6:0]    active-low segment lines {g,f,e,d,c,b,a}
//   digit    [3:0]    last accepted digit
//   score_lo [7:0]    digit*5
//   valid             one-cycle acceptance pulse
//   blank             accepted pattern is all-off
//   err              accepted pattern is undecodable
//   locked            FSM is in LOCKED
//   err_cnt  [7:0]    saturating count of err acceptances
//                     (only when SEG_READBACK_ERRCNT_EN is defined)
module seg_readback_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic [7:0] score_lo,
  output logic       valid,
  output logic       blank,
  output logic       err,
  output logic       locked
`ifdef SEG_READBACK_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  seg_state_t r_state;
  logic [3:0] r_cnt;
  logic [6:0] r_seg_q;
  logic [6:0] r_seg_p;
  logic [3:0] r_digit;
  logic [7:0] r_score_lo;
  logic       r_valid;
  logic       r_blank;
  logic       r_err;
  logic       r_locked;

  logic [3:0] w_lut_digit;
  logic       w_is_digit;
  logic       w_is_blank;
  logic       w_same;
  logic [7:0] w_score;

  seg_pattern_lut u_lut (
    .i_seg      (r_seg_q),
    .o_digit    (w_lut_digit),
    .o_is_digit (w_is_digit),
    .o_is_blank (w_is_blank)
  );

  assign w_same  = (r_seg_q == r_seg_p);
  // digit*5 = digit*4 + digit; at most 45, fits comfortably in 8 bits.
  assign w_score = {2'b00, w_lut_digit, 2'b00} + {4'b0000, w_lut_digit};

`ifdef SEG_READBACK_ERRCNT_EN
  logic [7:0] r_err_cnt;
  assign err_cnt = r_err_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_seg_q    <= SEG_BLANK;
      r_seg_p    <= SEG_BLANK;
      r_digit    <= '0;
      r_score_lo <= '0;
      r_valid    <= 1'b0;
      r_blank    <= 1'b1;
      r_err      <= 1'b0;
      r_locked   <= 1'b0;
`ifdef SEG_READBACK_ERRCNT_EN
      r_err_cnt  <= '0;
`endif
    end else begin
      r_seg_q <= seg;
      r_seg_p <= r_seg_q;
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_SETTLE;
          r_cnt   <= 4'd1;
        end
        ST_SETTLE: begin
          if (!w_same) begin
            r_cnt <= 4'd1;
          end else if (r_cnt == CNT_MAX) begin
            // Count has saturated and the sample is still unchanged: accept.
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
            r_valid  <= 1'b1;
            if (w_is_digit) begin
              r_digit    <= w_lut_digit;
              r_score_lo <= w_score;
              r_blank    <= 1'b0;
              r_err      <= 1'b0;
            end else if (w_is_blank) begin
              r_blank <= 1'b1;
              r_err   <= 1'b0;
            end else begin
              r_blank <= 1'b0;
              r_err   <= 1'b1;
`ifdef SEG_READBACK_ERRCNT_EN
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_LOCKED: begin
          // Any change restarts settling; decoded outputs keep their values.
          if (!w_same) begin
            r_state  <= ST_SETTLE;
            r_locked <= 1'b0;
            r_cnt    <= 4'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign digit    = r_digit;
  assign score_lo = r_score_lo;
  assign valid    = r_valid;
  assign blank    = r_blank;
  assign err      = r_err;
  assign locked   = r_locked;

endmodule

// File: tb/tb_seg_readback_decoder.sv
// tb_seg_readback_decoder -- randomized and directed self-checking bench.
//
// The reference model keeps the history of sampled seg values since reset and
// accepts a pattern whenever the last STABLE_CYCLES+1 register samples agree
// while not locked; any sample change drops lock.
// Optional feature macro: SEG_READBACK_ERRCNT_EN.
module tb_seg_readback_decoder;

  localparam int S = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg   = 7'h7F;
  logic [3:0] digit;
  logic [7:0] score_lo;
  logic       valid;
  logic       blank;
  logic       err;
  logic       locked;
`ifdef SEG_READBACK_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  seg_readback_decoder #(.STABLE_CYCLES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg      (seg),
    .digit    (digit),
    .score_lo (score_lo),
    .valid    (valid),
    .blank    (blank),
    .err      (err),
    .locked   (locked)
`ifdef SEG_READBACK_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  bit saw_unlock = 0;

  localparam logic [6:0] DIGIT_PAT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // ---------------- reference model ----------------
  logic [6:0] hist[$];
  int edge_n    = 0;
  bit m_locked  = 0;
  bit m_valid   = 0;
  bit m_blank   = 1;
  bit m_err     = 0;
  int m_digit   = 0;
  int m_err_cnt = 0;

  function automatic int pat_to_digit(logic [6:0] p);
    for (int i = 0; i < 10; i++) if (DIGIT_PAT[i] == p) return i;
    return -1;
  endfunction

  task automatic m_reset();
    hist.delete();
    hist.push_back(7'h7F);
    edge_n = 0; m_locked = 0; m_valid = 0; m_blank = 1; m_err = 0;
    m_digit = 0; m_err_cnt = 0;
  endtask

  task automatic m_accept(logic [6:0] p);
    int d;
    d = pat_to_digit(p);
    m_valid  = 1;
    m_locked = 1;
    if (d >= 0) begin
      m_digit = d; m_blank = 0; m_err = 0;
    end else if (p == 7'h7F) begin
      m_blank = 1; m_err = 0;
    end else begin
      m_blank = 0; m_err = 1;
      if (m_err_cnt < 255) m_err_cnt++;
    end
    $display("[TB] t=%0t accept seg=%02h digit=%0d blank=%0b err=%0b",
             $time, p, m_digit, m_blank, m_err);
  endtask

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model step on every rising edge, then compare just after the edge.
  always @(posedge clk) begin
    logic [6:0] cur;
    bit         eq;
    cur = seg;
    if (!rst_n) begin
      m_reset();
    end else begin
      edge_n++;
      m_valid = 0;
      if (edge_n >= 2) begin
        if (m_locked) begin
          if (hist[edge_n-1] != hist[edge_n-2]) m_locked = 0;
        end else if (edge_n - 1 - S >= 0) begin
          eq = 1;
          for (int j = 0; j <= S; j++)
            if (hist[edge_n-1-j] != hist[edge_n-1]) eq = 0;
          if (eq) m_accept(hist[edge_n-1]);
        end
      end
      hist.push_back(cur);
    end
    #1;
    n_tests++;
    if (valid !== m_valid || digit !== 4'(m_digit) || score_lo !== 8'(m_digit*5) ||
        blank !== m_blank || err !== m_err || locked !== m_locked
`ifdef SEG_READBACK_ERRCNT_EN
        || err_cnt !== 8'(m_err_cnt)
`endif
        ) begin
      n_fail++;
      $display("FAIL cycle t=%0t: got v=%0b d=%0d s=%0d b=%0b e=%0b l=%0b expected v=%0b d=%0d s=%0d b=%0b e=%0b l=%0b",
               $time, valid, digit, score_lo, blank, err, locked,
               m_valid, m_digit, m_digit*5, m_blank, m_err, m_locked);
    end
    if (valid === 1'b1) n_valid++;
    if (locked === 1'b0) saw_unlock = 1;
  end

  // ---------------- stimulus ----------------
  task automatic drive(logic [6:0] p, int n);
    seg = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int v0;
    int hold;
    int pick;
    logic [6:0] p;

    m_reset();
    @(negedge clk);
    #1;
    check("reset_digit", digit, 0);
    check("reset_blank", blank, 1);
    check("reset_locked", locked, 0);
    check("reset_valid", valid, 0);
    rst_n = 1;

    // Stable 7'h24 for 10 cycles: exactly one pulse, digit 2, score 10.
    do_reset();
    v0 = n_valid;
    drive(7'h24, 10);
    check("d2_pulses", n_valid - v0, 1);
    check("d2_digit", digit, 2);
    check("d2_score", score_lo, 10);
    check("d2_locked", locked, 1);
    check("d2_model_digit", m_digit, 2);

    // Toggling every 3 cycles never settles.
    do_reset();
    v0 = n_valid;
    for (int i = 0; i < 8; i++) drive((i % 2 == 0) ? 7'h30 : 7'h19, 3);
    check("toggle_pulses", n_valid - v0, 0);
    check("toggle_locked", locked, 0);
    check("toggle_digit", digit, 0);

    // Lock on 9, glitch to 8 for one cycle, recover.
    drive(7'h10, 10);
    check("d9_locked", locked, 1);
    saw_unlock = 0;
    v0 = n_valid;
    drive(7'h00, 1);
    drive(7'h10, 10);
    check("glitch_unlock", int'(saw_unlock), 1);
    check("glitch_pulses", n_valid - v0, 1);
    check("glitch_digit", digit, 9);
    check("glitch_score", score_lo, 45);

    // Undecodable pattern: err, digit held.
    drive(7'h55, 10);
    check("bad_err", err, 1);
    check("bad_digit", digit, 9);
    check("bad_model_err", int'(m_err), 1);

`ifdef SEG_READBACK_ERRCNT_EN
    for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 7'h2A : 7'h55, S + 3);
    check("errcnt_sat", err_cnt, 255);
`endif

    // Digit 7 then blank.
    drive(7'h78, 10);
    drive(7'h7F, 10);
    check("blank_blank", blank, 1);
    check("blank_digit", digit, 7);
    check("blank_score", score_lo, 35);

    // Reset mid-settle (cnt=2): everything back to reset values, no pulse.
    v0 = n_valid;
    drive(7'h24, 3);
    rst_n = 0;
    #1;
    check("midrst_digit", digit, 0);
    check("midrst_score", score_lo, 0);
    check("midrst_blank", blank, 1);
    check("midrst_locked", locked, 0);
    check("midrst_valid", valid, 0);
    repeat (2) @(negedge clk);
    check("midrst_pulses", n_valid - v0, 0);
    rst_n = 1;

    // Randomized segments with random hold times and occasional resets.
    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 11);
      if (pick < 10)       p = DIGIT_PAT[pick];
      else if (pick == 10) p = 7'h7F;
      else                 p = 7'($urandom_range(0, 127));
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) do_reset();
      drive(p, hold);
    end
    drive(7'h7F, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_readback_decoder.md
SEG_READBACK_DECODER -- requirements
Module: seg_readback_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 2..15, giving consecutive identical samples required to accept a pattern.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port seg, input, 7, active-low segment lines {g,f,e,d,c,b,a}, bit0 = a; same encoding the score display drives.
REQ-005 SHALL have port digit, output, 4, last accepted decimal digit 0..9.
REQ-006 SHALL have port score_lo, output, 8, digit*5, the lowest score mapping to that digit.
REQ-007 SHALL have port valid, output, 1, one-cycle pulse on each acceptance.
REQ-008 SHALL have port blank, output, 1, high while the accepted pattern is all-off (7'h7F).
REQ-009 SHALL have port err, output, 1, high while the accepted pattern is undecodable.
REQ-010 SHALL have port locked, output, 1, high in state LOCKED.

Function
REQ-011 SHALL register seg into seg_q every cycle; all comparisons use seg_q against the previous sample seg_p.
REQ-012 SHALL implement FSM IDLE, SETTLE, LOCKED; stable counter cnt 4 bits, saturating at STABLE_CYCLES.
REQ-013 IDLE: first sample after reset -> SETTLE, cnt=1.
REQ-014 SETTLE: seg_q==seg_p -> cnt+1; seg_q!=seg_p -> cnt=1, stay SETTLE; cnt reaching STABLE_CYCLES -> LOCKED and accept seg_q.
REQ-015 LOCKED: seg_q==seg_p -> stay, no further pulses; seg_q!=seg_p -> SETTLE, cnt=1, outputs digit/score_lo/blank/err held.
REQ-016 Acceptance latency: pattern stable at seg from edge k -> valid high in the cycle beginning at edge k+STABLE_CYCLES+1.
REQ-017 Acceptance of pattern for 0..9 (7'h40,79,24,30,19,12,02,78,00,10): digit and score_lo update, blank=0, err=0, valid=1 for one cycle.
REQ-018 Acceptance of 7'h7F: blank=1, err=0, digit/score_lo held, valid pulses.
REQ-019 Acceptance of any other pattern: err=1, blank=0, digit/score_lo held, valid pulses.
REQ-020 Re-acceptance of a pattern identical to the previously accepted one (glitch recovery) SHALL still pulse valid.
REQ-021 score_lo SHALL be computed as 8-bit unsigned digit*5, max 45, no overflow.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, cnt=0, seg_q=seg_p=7'h7F, digit=0, score_lo=0, valid=0, blank=1, err=0, locked=0.
REQ-023 Reset mid-SETTLE SHALL discard partial count; no valid pulse for the interrupted pattern.
REQ-024 Deassertion SHALL take effect at the first rising clk edge after rst_n goes high.

Configuration
REQ-025 Macro SEG_READBACK_ERRCNT_EN defined: adds output err_cnt, 8 bits, reset 0, +1 on each err acceptance, saturating at 255.
REQ-026 Macro undefined: port err_cnt and its counter absent; all other behaviour identical.

Structure
REQ-027 Shared package seg_pkg SHALL hold the ten digit pattern constants, SEG_BLANK, and the FSM state enum.
REQ-028 One sub-module seg_pattern_lut (combinational seg -> digit, is_digit, is_blank) SHALL be instantiated; FSM and counters stay in the top.

Verification
REQ-029 Reset, then seg=7'h24 held 10 cycles, STABLE_CYCLES=4 -> single valid pulse at edge k+5, digit=2, score_lo=10, locked=1.
REQ-030 seg toggles 7'h30/7'h19 every 3 cycles, STABLE_CYCLES=4 -> no valid, locked=0, digit stays 0.
REQ-031 Locked on 7'h10, one-cycle glitch to 7'h00, back to 7'h10 -> locked drops, then one valid pulse, digit=9, score_lo=45.
REQ-032 seg=7'h55 held -> valid pulse, err=1, digit unchanged; with SEG_READBACK_ERRCNT_EN, 300 such acceptances -> err_cnt=255.
REQ-033 seg=7'h7F held after digit 7 -> blank=1, digit=7, score_lo=35; rst_n pulsed low at SETTLE cnt=2 -> all outputs at reset values, no pulse.
